// File: rtl/dma_pkg.sv
// Shared constants and types for the DMA channel register bank.
package dma_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int REG_W_DEF  = 2 * DATA_W_DEF;

    localparam logic REG_SEL_ADDR = 1'b0;
    localparam logic REG_SEL_CNT  = 1'b1;

    typedef struct packed {
        logic [REG_W_DEF-1:0] addr;
        logic [REG_W_DEF-1:0] cnt;
    } reg_pair_t;

endpackage

// File: rtl/dma_chan_slice.sv
// One DMA channel: address/count registers, byte-wise host writes and step logic.
// Optional base copies and auto-initialise under DMA_CHAN_AUTOINIT_EN.
module dma_chan_slice
    import dma_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_RST = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic                wr_hi,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                step,
    input  logic                dec,
`ifdef DMA_CHAN_AUTOINIT_EN
    input  logic                autoinit,
`endif
    output logic [2*DATA_W-1:0] addr,
    output logic [2*DATA_W-1:0] cnt,
    output logic                done,
    output logic                tc_evt
);

    localparam int REG_W = 2 * DATA_W;
    localparam logic [REG_W-1:0] ADDR_INIT = REG_W'(ADDR_RST);

    logic [REG_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             blocked;
    logic             step_ok;

    function automatic logic [REG_W-1:0] put_byte(input logic [REG_W-1:0] v,
                                                  input logic hi,
                                                  input logic [DATA_W-1:0] b);
        put_byte = v;
        if (hi) put_byte[REG_W-1:DATA_W] = b;
        else    put_byte[DATA_W-1:0]     = b;
    endfunction

`ifdef DMA_CHAN_AUTOINIT_EN
    logic [REG_W-1:0] base_addr_q, base_addr_d;
    logic [REG_W-1:0] base_cnt_q, base_cnt_d;

    // An auto-initialising channel keeps stepping after terminal count.
    assign blocked = done_q & ~autoinit;
`else
    assign blocked = done_q;
`endif

    // A host write to this channel wins over a step in the same cycle.
    assign step_ok = step & ~wr_en & ~blocked;
    assign tc_evt  = step_ok && (cnt_q == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        addr_d = addr_q;
        cnt_d  = cnt_q;
        done_d = done_q;
`ifdef DMA_CHAN_AUTOINIT_EN
        base_addr_d = base_addr_q;
        base_cnt_d  = base_cnt_q;
`endif
        if (wr_en) begin
            if (wr_sel == REG_SEL_CNT) begin
                cnt_d  = put_byte(cnt_q, wr_hi, wr_data);
                done_d = 1'b0;
`ifdef DMA_CHAN_AUTOINIT_EN
                base_cnt_d = put_byte(base_cnt_q, wr_hi, wr_data);
`endif
            end else begin
                addr_d = put_byte(addr_q, wr_hi, wr_data);
`ifdef DMA_CHAN_AUTOINIT_EN
                base_addr_d = put_byte(base_addr_q, wr_hi, wr_data);
`endif
            end
        end else if (step_ok) begin
            addr_d = dec ? addr_q - 1'b1 : addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                done_d = 1'b1;
`ifdef DMA_CHAN_AUTOINIT_EN
                if (autoinit) begin
                    addr_d = base_addr_q;
                    cnt_d  = base_cnt_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!rst) begin
            addr_q <= ADDR_INIT;
            cnt_q  <= '0;
            done_q <= 1'b0;
`ifdef DMA_CHAN_AUTOINIT_EN
            base_addr_q <= ADDR_INIT;
            base_cnt_q  <= '0;
`endif
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
`ifdef DMA_CHAN_AUTOINIT_EN
            base_addr_q <= base_addr_d;
            base_cnt_q  <= base_cnt_d;
`endif
        end
    end

    assign addr = addr_q;
    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/dma_chan_regs.sv
// Bank of NUM_CH DMA channel address/count registers with byte-serial host access.
// Define DMA_CHAN_AUTOINIT_EN to add the autoinit port and base-copy reload.
module dma_chan_regs
    import dma_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_CH   = 4,
    parameter  int ADDR_RST = 0,
    localparam int REG_W    = 2 * DATA_W,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              read,
    input  logic              clr_ptr,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              reg_sel,
    input  logic [DATA_W-1:0] Data_In,
    output logic [DATA_W-1:0] Data_Out,
    input  logic [NUM_CH-1:0] dec_mode,
    input  logic              xfer,
    input  logic [CH_W-1:0]   xfer_ch,
`ifdef DMA_CHAN_AUTOINIT_EN
    input  logic [NUM_CH-1:0] autoinit,
`endif
    output logic [REG_W-1:0]  cur_addr,
    output logic              tc,
    output logic [NUM_CH-1:0] done,
    output logic              byte_ptr
);

    localparam int NUM_SLOT = 2 ** CH_W;

    logic [REG_W-1:0]  addr_arr [NUM_SLOT];
    logic [REG_W-1:0]  cnt_arr  [NUM_SLOT];
    logic [NUM_CH-1:0] tc_evt;
    logic [NUM_CH-1:0] done_vec;

    logic              byte_ptr_q, byte_ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              tc_q, tc_d;
    logic [REG_W-1:0]  sel_reg;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dma_chan_slice #(
            .DATA_W   (DATA_W),
            .ADDR_RST (ADDR_RST)
        ) u_slice (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (~load && (ch_sel == CH_W'(i))),
            .wr_sel   (reg_sel),
            .wr_hi    (byte_ptr_q),
            .wr_data  (Data_In),
            .step     (xfer && (xfer_ch == CH_W'(i))),
            .dec      (dec_mode[i]),
`ifdef DMA_CHAN_AUTOINIT_EN
            .autoinit (autoinit[i]),
`endif
            .addr     (addr_arr[i]),
            .cnt      (cnt_arr[i]),
            .done     (done_vec[i]),
            .tc_evt   (tc_evt[i])
        );
    end

    // Unused select codes read as zero when NUM_CH is not a power of two.
    for (genvar i = NUM_CH; i < NUM_SLOT; i++) begin : g_pad
        assign addr_arr[i] = '0;
        assign cnt_arr[i]  = '0;
    end

    always_comb begin
        sel_reg    = (reg_sel == REG_SEL_CNT) ? cnt_arr[ch_sel] : addr_arr[ch_sel];
        data_out_d = data_out_q;
        if (!read && load)
            data_out_d = byte_ptr_q ? sel_reg[REG_W-1:DATA_W] : sel_reg[DATA_W-1:0];

        byte_ptr_d = byte_ptr_q;
        if (!clr_ptr)
            byte_ptr_d = 1'b0;
        else if (!load || !read)
            byte_ptr_d = ~byte_ptr_q;

        // At most one channel is stepped per cycle.
        tc_d = |tc_evt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ptr_q <= 1'b0;
            data_out_q <= '0;
            tc_q       <= 1'b0;
        end else begin
            byte_ptr_q <= byte_ptr_d;
            data_out_q <= data_out_d;
            tc_q       <= tc_d;
        end
    end

    assign Data_Out = data_out_q;
    assign byte_ptr = byte_ptr_q;
    assign tc       = tc_q;
    assign done     = done_vec;
    assign cur_addr = addr_arr[xfer_ch];

endmodule

// File: tb/tb_dma_chan_regs.sv
// Self-checking bench for dma_chan_regs: directed plan plus randomized traffic
// against a behavioural register-bank model.
module tb_dma_chan_regs;
    import dma_pkg::*;

    logic        clk;
    logic        rst;
    logic        load, read, clr_ptr, reg_sel, xfer;
    logic [1:0]  ch_sel, xfer_ch;
    logic [7:0]  Data_In;
    logic [7:0]  Data_Out;
    logic [3:0]  dec_mode;
    logic [15:0] cur_addr;
    logic        tc;
    logic [3:0]  done;
    logic        byte_ptr;
`ifdef DMA_CHAN_AUTOINIT_EN
    logic [3:0]  autoinit;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    dma_chan_regs #(.DATA_W(8), .NUM_CH(4), .ADDR_RST(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .read     (read),
        .clr_ptr  (clr_ptr),
        .ch_sel   (ch_sel),
        .reg_sel  (reg_sel),
        .Data_In  (Data_In),
        .Data_Out (Data_Out),
        .dec_mode (dec_mode),
        .xfer     (xfer),
        .xfer_ch  (xfer_ch),
`ifdef DMA_CHAN_AUTOINIT_EN
        .autoinit (autoinit),
`endif
        .cur_addr (cur_addr),
        .tc       (tc),
        .done     (done),
        .byte_ptr (byte_ptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    reg_pair_t  m_cur  [4];
    reg_pair_t  m_base [4];
    logic [3:0] m_done;
    logic       m_ptr, m_tc;
    logic [7:0] m_dout;

    function automatic logic [15:0] put(input logic [15:0] v, input logic hi, input logic [7:0] b);
        return hi ? {b, v[7:0]} : {v[15:8], b};
    endfunction

    function automatic logic ai_bit(input int c);
`ifdef DMA_CHAN_AUTOINIT_EN
        return autoinit[c];
`else
        return (c < 0);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cur[i]  = '{addr: 16'h0000, cnt: 16'h0000};
            m_base[i] = '{addr: 16'h0000, cnt: 16'h0000};
        end
        m_done = '0;
        m_ptr  = 1'b0;
        m_tc   = 1'b0;
        m_dout = '0;
    endtask

    task automatic model_cycle();
        logic wr, rd, tc_n;
        logic [15:0] v;
        int c, s;
        wr   = !load;
        rd   = !read;
        tc_n = 1'b0;
        s    = int'(ch_sel);
        c    = int'(xfer_ch);
        v    = reg_sel ? m_cur[s].cnt : m_cur[s].addr;
        if (rd && !wr) m_dout = m_ptr ? v[15:8] : v[7:0];
        if (wr) begin
            if (reg_sel) begin
                m_cur[s].cnt  = put(m_cur[s].cnt, m_ptr, Data_In);
                m_base[s].cnt = put(m_base[s].cnt, m_ptr, Data_In);
                m_done[s]     = 1'b0;
            end else begin
                m_cur[s].addr  = put(m_cur[s].addr, m_ptr, Data_In);
                m_base[s].addr = put(m_base[s].addr, m_ptr, Data_In);
            end
        end
        if (xfer && !(wr && s == c) && (!m_done[c] || ai_bit(c))) begin
            m_cur[c].addr = dec_mode[c] ? m_cur[c].addr - 16'd1 : m_cur[c].addr + 16'd1;
            if (m_cur[c].cnt == 16'd0) begin
                tc_n      = 1'b1;
                m_done[c] = 1'b1;
                if (ai_bit(c)) m_cur[c] = m_base[c];
                else           m_cur[c].cnt = 16'hFFFF;
            end else begin
                m_cur[c].cnt = m_cur[c].cnt - 16'd1;
            end
        end
        m_tc = tc_n;
        if (!clr_ptr)      m_ptr = 1'b0;
        else if (wr || rd) m_ptr = !m_ptr;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_cycle();
    end

    // Compare every cycle on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out", 32'(Data_Out), 32'(m_dout));
            check("tc",       32'(tc),       32'(m_tc));
            check("done",     32'(done),     32'(m_done));
            check("byte_ptr", 32'(byte_ptr), 32'(m_ptr));
            check("cur_addr", 32'(cur_addr), 32'(m_cur[int'(xfer_ch)].addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load = 1'b1; read = 1'b1; clr_ptr = 1'b1; xfer = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic sel, input logic [7:0] d);
        ch_sel = ch; reg_sel = sel; Data_In = d; load = 1'b0;
        tick();
        load = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] ch, input logic sel, input logic [7:0] exp);
        ch_sel = ch; reg_sel = sel; read = 1'b0;
        tick();
        read = 1'b1;
        check(name, 32'(Data_Out), 32'(exp));
    endtask

    task automatic step(input logic [1:0] ch);
        xfer_ch = ch; xfer = 1'b1;
        tick();
        xfer = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_ptr = 1'b0;
        tick();
        clr_ptr = 1'b1;
        check("clr_ptr", 32'(byte_ptr), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        ch_sel = '0; reg_sel = 1'b0; Data_In = '0; xfer_ch = '0; dec_mode = '0;
`ifdef DMA_CHAN_AUTOINIT_EN
        autoinit = '0;
`endif
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_dout", 32'(Data_Out), 32'd0);
        check("rst_tc",   32'(tc),       32'd0);
        check("rst_done", 32'(done),     32'd0);
        check("rst_ptr",  32'(byte_ptr), 32'd0);
        check("rst_addr", 32'(cur_addr), 32'd0);
        rst = 1'b1;
        tick();

        // Byte-serial load and read-back of ch1 address.
        wr(2'd1, REG_SEL_ADDR, 8'h34);
        check("ptr_after_lo", 32'(byte_ptr), 32'd1);
        wr(2'd1, REG_SEL_ADDR, 8'h12);
        check("ptr_after_hi", 32'(byte_ptr), 32'd0);
        xfer_ch = 2'd1;
        #1;
        check("ch1_addr", 32'(cur_addr), 32'h1234);
        check("model_ch1_addr", 32'(m_cur[1].addr), 32'h1234);
        rd_chk("rd_lo", 2'd1, REG_SEL_ADDR, 8'h34);
        rd_chk("rd_hi", 2'd1, REG_SEL_ADDR, 8'h12);

        // Incrementing ch0 through terminal count.
        wr(2'd0, REG_SEL_ADDR, 8'hFF); wr(2'd0, REG_SEL_ADDR, 8'h00);
        wr(2'd0, REG_SEL_CNT,  8'h02); wr(2'd0, REG_SEL_CNT,  8'h00);
        step(2'd0); check("inc1", 32'(cur_addr), 32'h0100); check("inc1_tc", 32'(tc), 32'd0);
        step(2'd0); check("inc2", 32'(cur_addr), 32'h0101);
        step(2'd0); check("inc3", 32'(cur_addr), 32'h0102); check("inc3_tc", 32'(tc), 32'd1);
        check("done0", 32'(done[0]), 32'd1);
        step(2'd0); check("blocked_addr", 32'(cur_addr), 32'h0102); check("blocked_tc", 32'(tc), 32'd0);

        // Decrement wrap on ch2 with count 0.
        dec_mode = 4'b0100;
        wr(2'd2, REG_SEL_ADDR, 8'h00); wr(2'd2, REG_SEL_ADDR, 8'h00);
        wr(2'd2, REG_SEL_CNT,  8'h00); wr(2'd2, REG_SEL_CNT,  8'h00);
        step(2'd2); check("dec_wrap", 32'(cur_addr), 32'hFFFF); check("dec_tc", 32'(tc), 32'd1);
        rd_chk("cnt2_lo", 2'd2, REG_SEL_CNT, 8'hFF);
        rd_chk("cnt2_hi", 2'd2, REG_SEL_CNT, 8'hFF);
        check("model_cnt2", 32'(m_cur[2].cnt), 32'hFFFF);

        // clr_ptr re-targets the low byte.
        wr(2'd3, REG_SEL_CNT, 8'h11); wr(2'd3, REG_SEL_CNT, 8'h22);
        wr(2'd3, REG_SEL_CNT, 8'h33);
        clr_pulse();
        wr(2'd3, REG_SEL_CNT, 8'hAA);
        clr_pulse();
        rd_chk("clr_lo", 2'd3, REG_SEL_CNT, 8'hAA);
        rd_chk("clr_hi", 2'd3, REG_SEL_CNT, 8'h22);

        // Write and step collisions.
        wr(2'd0, REG_SEL_CNT, 8'h05); wr(2'd0, REG_SEL_CNT, 8'h00);
        check("done0_clr", 32'(done[0]), 32'd0);
        ch_sel = 2'd1; reg_sel = REG_SEL_CNT; Data_In = 8'h77; load = 1'b0;
        xfer_ch = 2'd1; xfer = 1'b1;
        tick();
        check("coll_addr", 32'(cur_addr), 32'h1234);
        check("coll_tc", 32'(tc), 32'd0);
        Data_In = 8'h00; xfer_ch = 2'd0;
        tick();
        idle();
        check("par_step", 32'(cur_addr), 32'h0103);
        rd_chk("coll_cnt_lo", 2'd1, REG_SEL_CNT, 8'h77);
        rd_chk("coll_cnt_hi", 2'd1, REG_SEL_CNT, 8'h00);
        rd_chk("par_cnt_lo",  2'd0, REG_SEL_CNT, 8'h04);
        tick();

`ifdef DMA_CHAN_AUTOINIT_EN
        autoinit = 4'b0001;
        clr_pulse();
        wr(2'd0, REG_SEL_ADDR, 8'h40); wr(2'd0, REG_SEL_ADDR, 8'h00);
        wr(2'd0, REG_SEL_CNT,  8'h01); wr(2'd0, REG_SEL_CNT,  8'h00);
        step(2'd0); check("ai_step1", 32'(cur_addr), 32'h0041);
        step(2'd0); check("ai_reload", 32'(cur_addr), 32'h0040); check("ai_tc", 32'(tc), 32'd1);
        check("ai_done", 32'(done[0]), 32'd1);
        step(2'd0); check("ai_step3", 32'(cur_addr), 32'h0041); check("ai_tc3", 32'(tc), 32'd0);
`endif

        // Randomized traffic, with the occasional mid-sequence reset.
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            load     = ($urandom_range(0, 9) >= 3);
            read     = ($urandom_range(0, 9) >= 3);
            clr_ptr  = ($urandom_range(0, 9) >= 1);
            xfer     = ($urandom_range(0, 9) >= 6);
            ch_sel   = 2'($urandom);
            xfer_ch  = 2'($urandom);
            reg_sel  = 1'($urandom);
            Data_In  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if (i % 40 == 0) dec_mode = 4'($urandom);
`ifdef DMA_CHAN_AUTOINIT_EN
            if (i % 50 == 0) autoinit = 4'($urandom);
`endif
            tick();
        end
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
